dl_rom_region: RTL

//  Parametrised CPU program ROM loaded over the MiST ioctl download stream. Claims one address window of the

---
 rtl/dl_rom_pkg.sv | 26 ++
 rtl/ram.sv | 24 ++
 rtl/dl_rom_region.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dl_rom_pkg.sv
// Shared types and constants for the ioctl-loaded program ROM regions.
package dl_rom_pkg;

    localparam int         IOCTL_AW     = 27;
    localparam logic [7:0] DL_FILL_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } dl_state_e;

    // True when addr lies in [base, base + 2**aw); one extra bit keeps the upper bound from overflowing.
    function automatic logic in_window(input logic [IOCTL_AW-1:0] addr,
                                       input logic [IOCTL_AW-1:0] base,
                                       input int                  aw);
        logic [IOCTL_AW:0] a_v;
        logic [IOCTL_AW:0] lo_v;
        logic [IOCTL_AW:0] hi_v;
        a_v  = {1'b0, addr};
        lo_v = {1'b0, base};
        hi_v = lo_v + ({{IOCTL_AW{1'b0}}, 1'b1} << aw);
        return (a_v >= lo_v) && (a_v < hi_v);
    endfunction

endpackage

// File: rtl/ram.sv
// Generic single-port RAM: synchronous write, combinational read of the shared address.
module ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          we,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem_r [0:(1<<AW)-1];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
    end

    assign q = mem_r[addr];

endmodule

// File: rtl/dl_rom_region.sv
// CPU program ROM region filled from the ioctl download stream, with registered read port.
// Optional byte-sum of downloaded data is built when ROM_CHECKSUM_EN is defined.
module dl_rom_region
    import dl_rom_pkg::*;
#(
    parameter int                  AW   = 15,
    parameter logic [IOCTL_AW-1:0] BASE = 27'd0,
    parameter int                  DL16 = 1
) (
    input  logic                clk_sys,
    input  logic                rst_n,
    input  logic [AW-1:0]       cpu_ab,
    output logic [7:0]          rom_data,
    input  logic                ioctl_download,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [15:0]         ioctl_dout,
    input  logic                ioctl_wr,
    output logic                loaded,
    output logic                overrun,
    output logic [15:0]         checksum
);

    localparam logic [AW-1:0] TOP_OFF = {AW{1'b1}};
    localparam bit            DL16_EN = (DL16 != 0);

    dl_state_e     state_r;
    dl_state_e     state_s;
    logic [AW-1:0] off_r;
    logic [15:0]   dout_r;
    logic          dl_r;
    logic          overrun_r;
    logic          loaded_r;
    logic          fall_pend_r;
    logic          top_wr_r;
    logic [7:0]    rom_data_r;

    logic          hit_s;
    logic          rise_s;
    logic          fall_s;
    logic [AW-1:0] hit_off_s;
    logic          we_s;
    logic [AW-1:0] woff_s;
    logic [7:0]    wdata_s;
    logic [AW-1:0] ram_addr_s;
    logic [7:0]    q_s;

    assign hit_s     = ioctl_wr & ioctl_download & in_window(ioctl_addr, BASE, AW);
    assign rise_s    = ioctl_download & ~dl_r;
    assign fall_s    = ~ioctl_download & dl_r;
    assign hit_off_s = ioctl_addr[AW-1:0] - BASE[AW-1:0];

    // FSM state register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: the high byte is skipped when the low byte sits at the top of the window.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (hit_s) state_s = LO;
                else       state_s = IDLE;
            end
            LO: begin
                if (DL16_EN && (off_r != TOP_OFF)) state_s = HI;
                else                               state_s = IDLE;
            end
            HI:      state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs: byte write strobe, write offset and data.
    always_comb begin
        we_s    = 1'b0;
        woff_s  = off_r;
        wdata_s = dout_r[7:0];
        case (state_r)
            LO: begin
                we_s = 1'b1;
            end
            HI: begin
                we_s    = 1'b1;
                woff_s  = off_r + {{(AW-1){1'b0}}, 1'b1};
                wdata_s = dout_r[15:8];
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Storage address: the pending write owns the port while the FSM is busy.
    always_comb begin
        if (state_r != IDLE) ram_addr_s = woff_s;
        else                 ram_addr_s = cpu_ab;
    end

    // Capture offset and data of an accepted strobe.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            off_r  <= {AW{1'b0}};
            dout_r <= 16'h0000;
        end else if ((state_r == IDLE) && hit_s) begin
            off_r  <= hit_off_s;
            dout_r <= ioctl_dout;
        end
    end

    // Download edge detector, overrun flag and top-byte tracking.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            dl_r      <= 1'b0;
            overrun_r <= 1'b0;
            top_wr_r  <= 1'b0;
        end else begin
            dl_r <= ioctl_download;
            if (rise_s)                          overrun_r <= 1'b0;
            else if (hit_s && state_r != IDLE)   overrun_r <= 1'b1;
            if (rise_s)                          top_wr_r <= 1'b0;
            else if (we_s && woff_s == TOP_OFF)  top_wr_r <= 1'b1;
        end
    end

    // Completion flag; a falling edge seen while a write is pending is held until the FSM idles.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            loaded_r    <= 1'b0;
            fall_pend_r <= 1'b0;
        end else if (rise_s) begin
            loaded_r    <= 1'b0;
            fall_pend_r <= 1'b0;
        end else if ((fall_s || fall_pend_r) && state_r == IDLE) begin
            loaded_r    <= top_wr_r;
            fall_pend_r <= 1'b0;
        end else if (fall_s) begin
            fall_pend_r <= 1'b1;
        end
    end

    // Registered CPU read data, masked while a download is in progress.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rom_data_r <= DL_FILL_BYTE;
        end else if (ioctl_download) begin
            rom_data_r <= DL_FILL_BYTE;
        end else begin
            rom_data_r <= q_s;
        end
    end

    ram #(AW, 8) u_ram (
        .clk  (clk_sys),
        .addr (ram_addr_s),
        .din  (wdata_s),
        .we   (we_s),
        .q    (q_s)
    );

`ifdef ROM_CHECKSUM_EN
    logic [15:0] sum_r;

    // Byte-sum of everything written during the current download.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= 16'h0000;
        end else if (rise_s) begin
            sum_r <= 16'h0000;
        end else if (we_s) begin
            sum_r <= sum_r + {8'h00, wdata_s};
        end
    end

    assign checksum = sum_r;
`else
    assign checksum = 16'h0000;
`endif

    assign rom_data = rom_data_r;
    assign loaded   = loaded_r;
    assign overrun  = overrun_r;

endmodule
